// File: rtl/mem_arbiter_2p.sv
// Two-port waitrequest arbiter in front of one single-port memory slave.
// Grants one whole transaction at a time and always returns through IDLE between grants.
module mem_arbiter_2p #(
  parameter int AW         = 18,
  parameter int DW         = 36,
  parameter int FIXED_PRIO = 0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [AW-1:0] i_p0_address,
  input  logic          i_p0_read,
  input  logic          i_p0_write,
  input  logic [DW-1:0] i_p0_writedata,
  output logic [DW-1:0] o_p0_readdata,
  output logic          o_p0_waitrequest,
  input  logic [AW-1:0] i_p1_address,
  input  logic          i_p1_read,
  input  logic          i_p1_write,
  input  logic [DW-1:0] i_p1_writedata,
  output logic [DW-1:0] o_p1_readdata,
  output logic          o_p1_waitrequest,
  output logic [AW-1:0] o_m_address,
  output logic          o_m_read,
  output logic          o_m_write,
  output logic [DW-1:0] o_m_writedata,
  input  logic [DW-1:0] i_m_readdata,
  input  logic          i_m_waitrequest,
  output logic [1:0]    o_grant,
  output logic          o_busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, state_nxt;
  logic   gnt, gnt_nxt;    // latched winner: 0 = port 0, 1 = port 1
  logic   last, last_nxt;  // port that most recently completed a transaction
  logic   req0, req1, req_g;

  assign req0  = i_p0_read | i_p0_write;
  assign req1  = i_p1_read | i_p1_write;
  assign req_g = gnt ? req1 : req0;

  assign o_p0_readdata = i_m_readdata;
  assign o_p1_readdata = i_m_readdata;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = BUSY;
          if (req0 && req1) gnt_nxt = (FIXED_PRIO != 0) ? 1'b0 : ~last;
          else              gnt_nxt = req1;
        end
      end
      BUSY: begin
        // A requester that drops its strobes mid-transaction forfeits without updating fairness.
        if (!req_g) begin
          state_nxt = IDLE;
        end else if (!i_m_waitrequest) begin
          state_nxt = IDLE;
          last_nxt  = gnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_m_address      = '0;
    o_m_writedata    = '0;
    o_m_read         = 1'b0;
    o_m_write        = 1'b0;
    o_grant          = 2'b00;
    o_busy           = 1'b0;
    o_p0_waitrequest = 1'b1;
    o_p1_waitrequest = 1'b1;
    if (state == BUSY) begin
      o_busy  = 1'b1;
      o_grant = gnt ? 2'b10 : 2'b01;
      // A simultaneous read and write is treated as a write.
      if (gnt) begin
        o_m_address      = i_p1_address;
        o_m_writedata    = i_p1_writedata;
        o_m_write        = i_p1_write;
        o_m_read         = i_p1_read & ~i_p1_write;
        o_p1_waitrequest = i_m_waitrequest;
      end else begin
        o_m_address      = i_p0_address;
        o_m_writedata    = i_p0_writedata;
        o_m_write        = i_p0_write;
        o_m_read         = i_p0_read & ~i_p0_write;
        o_p0_waitrequest = i_m_waitrequest;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Bench for mem_arbiter_2p: directed scenarios plus randomized two-port traffic,
// scored against a transaction-level memory and fairness model.
module tb_mem_arbiter_2p;
  localparam int AW = 18;
  localparam int DW = 36;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] p0_address = '0, p1_address = '0;
  logic          p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
  logic [DW-1:0] p0_writedata = '0, p1_writedata = '0;
  logic [DW-1:0] p0_readdata, p1_readdata;
  logic          p0_wait, p1_wait;
  logic [AW-1:0] m_address;
  logic          m_read, m_write;
  logic [DW-1:0] m_writedata, m_readdata;
  logic          m_wait = 1'b0;
  logic [1:0]    grant;
  logic          busy;

  mem_arbiter_2p #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_p0_address(p0_address), .i_p0_read(p0_read), .i_p0_write(p0_write),
    .i_p0_writedata(p0_writedata), .o_p0_readdata(p0_readdata), .o_p0_waitrequest(p0_wait),
    .i_p1_address(p1_address), .i_p1_read(p1_read), .i_p1_write(p1_write),
    .i_p1_writedata(p1_writedata), .o_p1_readdata(p1_readdata), .o_p1_waitrequest(p1_wait),
    .o_m_address(m_address), .o_m_read(m_read), .o_m_write(m_write),
    .o_m_writedata(m_writedata), .i_m_readdata(m_readdata), .i_m_waitrequest(m_wait),
    .o_grant(grant), .o_busy(busy)
  );

  // Fixed-priority instance with its own always-ready slave.
  logic          fp_p0_read = 1'b0, fp_p1_read = 1'b0, fp_lo = 1'b0;
  logic [AW-1:0] fp_addr0 = 18'd1, fp_addr1 = 18'd2;
  logic [DW-1:0] fp_wd = '0, fp_mrd = '0;
  logic [DW-1:0] fp_p0_rdata, fp_p1_rdata, fp_m_writedata;
  logic          fp_p0_wait, fp_p1_wait, fp_m_read, fp_m_write, fp_busy;
  logic [AW-1:0] fp_m_address;
  logic [1:0]    fp_grant;

  mem_arbiter_2p #(.AW(AW), .DW(DW), .FIXED_PRIO(1)) dut_fp (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_p0_address(fp_addr0), .i_p0_read(fp_p0_read), .i_p0_write(fp_lo),
    .i_p0_writedata(fp_wd), .o_p0_readdata(fp_p0_rdata), .o_p0_waitrequest(fp_p0_wait),
    .i_p1_address(fp_addr1), .i_p1_read(fp_p1_read), .i_p1_write(fp_lo),
    .i_p1_writedata(fp_wd), .o_p1_readdata(fp_p1_rdata), .o_p1_waitrequest(fp_p1_wait),
    .o_m_address(fp_m_address), .o_m_read(fp_m_read), .o_m_write(fp_m_write),
    .o_m_writedata(fp_m_writedata), .i_m_readdata(fp_mrd), .i_m_waitrequest(fp_lo),
    .o_grant(fp_grant), .o_busy(fp_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory slave: small array, writes land on the completion cycle.
  logic [DW-1:0] slave_mem [0:255];
  bit            rand_stall = 1'b0;
  int            stall_cfg [2];
  int            bcnt = 0;

  assign m_readdata = slave_mem[m_address[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) slave_mem[i] = '0;
    stall_cfg[0] = 0;
    stall_cfg[1] = 0;
  end

  always @(negedge clk) begin
    if (rst_n && m_write && !m_wait) slave_mem[m_address[7:0]] = m_writedata;
  end

  always @(posedge clk) begin
    #1;
    if (rand_stall) begin
      m_wait = ($urandom_range(0, 2) == 0);
    end else if (busy) begin
      m_wait = (bcnt < stall_cfg[grant[1]]);
      bcnt++;
    end else begin
      bcnt   = 0;
      m_wait = 1'b0;
    end
  end

  // Scoreboard: issued transactions per port, reference memory, fairness pointer.
  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } rec_t;
  rec_t          q0[$];
  rec_t          q1[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            sb_en = 1'b0;
  bit            last_ref = 1'b1;
  bit            busy_prev = 1'b0, done_prev = 1'b0;
  logic [1:0]    req_prev = 2'b00, grant_prev = 2'b00;

  always @(negedge clk) begin
    logic [1:0]    req, exp_g;
    logic [DW-1:0] exp_d;
    bit            g, done;
    rec_t          r;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      last_ref  = 1'b1;
      busy_prev = 1'b0;
      done_prev = 1'b0;
      req_prev  = 2'b00;
    end else begin
      req = {p1_read | p1_write, p0_read | p0_write};
      if (done_prev) begin
        check("idle_between_grants", busy, 1'b0);
      end else if (busy_prev) begin
        check("grant_hold", {busy, grant}, {1'b1, grant_prev});
      end else begin
        if (req_prev == 2'b00)      exp_g = 2'b00;
        else if (req_prev == 2'b11) exp_g = last_ref ? 2'b01 : 2'b10;
        else                        exp_g = req_prev;
        check("arbitration", grant, exp_g);
      end
      if (!busy) check("idle_outputs", {grant, m_read, m_write, p0_wait, p1_wait}, 6'b000011);
      done = 1'b0;
      if (busy) begin
        g = grant[1];
        check("busy_waits", {p1_wait, p0_wait}, g ? {m_wait, 1'b1} : {1'b1, m_wait});
        if (!req[g]) begin
          check("abort_no_strobe", {m_read, m_write}, 2'b00);
          done = 1'b1;
        end else if (!m_wait) begin
          done     = 1'b1;
          last_ref = g;
          if (sb_en) begin
            check("sb_nonempty", (g ? q1.size() : q0.size()) != 0, 1'b1);
            if ((g ? q1.size() : q0.size()) != 0) begin
              r = g ? q1.pop_front() : q0.pop_front();
              check("m_strobes", {m_write, m_read}, r.wr ? 2'b10 : 2'b01);
              check("m_address", m_address, r.a);
              if (r.wr) begin
                check("m_writedata", m_writedata, r.d);
                ref_mem[r.a] = r.d;
              end else begin
                exp_d = ref_mem.exists(r.a) ? ref_mem[r.a] : '0;
                check("readdata", g ? p1_readdata : p0_readdata, exp_d);
              end
            end
          end
        end
      end
      busy_prev  = busy;
      req_prev   = req;
      done_prev  = done;
      grant_prev = grant;
    end
  end

  // One requester transaction; called just after a rising edge, returns just after one.
  task automatic txn(input int port, input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output int lowcyc, output int wcnt,
                     output logic [DW-1:0] rdata);
    rec_t r;
    r.wr = wr; r.a = a; r.d = d;
    if (port == 0) begin
      p0_address = a; p0_read = rd; p0_write = wr; p0_writedata = d; q0.push_back(r);
    end else begin
      p1_address = a; p1_read = rd; p1_write = wr; p1_writedata = d; q1.push_back(r);
    end
    lowcyc = 0;
    wcnt   = 0;
    rdata  = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (m_write && grant == ((port == 0) ? 2'b01 : 2'b10)) wcnt++;
      if (((port == 0) ? p0_wait : p1_wait) == 1'b0) begin
        lowcyc = c;
        rdata  = (port == 0) ? p0_readdata : p1_readdata;
        break;
      end
    end
    @(posedge clk); #1;
    if (port == 0) begin
      p0_read = 1'b0; p0_write = 1'b0; p0_address = '0; p0_writedata = '0;
    end else begin
      p1_read = 1'b0; p1_write = 1'b0; p1_address = '0; p1_writedata = '0;
    end
    check("txn_completes", lowcyc != 0, 1'b1);
  endtask

  task automatic requester(input int port, input int n);
    int            lc, wc, kind;
    logic [DW-1:0] rd;
    logic [63:0]   rv;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      kind = $urandom_range(0, 2);
      rv   = {$urandom(), $urandom()};
      txn(port, kind != 1, kind != 0, 18'($urandom_range(0, 31)), rv[DW-1:0], lc, wc, rd);
    end
  endtask

  task automatic wait_busy(output bit found);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin found = 1'b1; break; end
    end
  endtask

  logic [1:0] t2_exp [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

  initial begin
    int            lc, wc, lc1, wc1, cnt;
    logic [DW-1:0] rd, rd1;
    bit            found;

    repeat (2) @(posedge clk); #1;
    check("reset_ctrl", {busy, grant, m_read, m_write, p0_wait, p1_wait}, 7'b0000011);
    check("reset_bus", {m_address, m_writedata}, 54'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb_en = 1'b1;

    // Port 0 write with one stall cycle, then readback.
    stall_cfg[0] = 1;
    txn(0, 1'b0, 1'b1, 18'o000100, 36'o123456701234, lc, wc, rd);
    check("t1_wait_low_cycle", lc, 3);
    check("t1_write_cycles", wc, 2);
    stall_cfg[0] = 0;
    txn(0, 1'b1, 1'b0, 18'o000100, '0, lc, wc, rd);
    check("t1_readback", rd, 36'o123456701234);

    // Port 0 read arrives while port 1's stalled write is in progress.
    stall_cfg[1] = 3;
    fork
      txn(1, 1'b0, 1'b1, 18'd5, 36'h5A5A5A5A5, lc1, wc1, rd1);
      begin
        repeat (2) begin @(posedge clk); #1; end
        txn(0, 1'b1, 1'b0, 18'o000100, '0, lc, wc, rd);
      end
    join
    check("t4_p1_wait_low_cycle", lc1, 5);
    check("t4_p0_wait_low_cycle", lc, 5);
    check("t4_p0_data", rd, 36'o123456701234);
    stall_cfg[1] = 0;

    // Round-robin under continuous contention right after reset.
    sb_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    p0_read = 1'b1; p0_address = 18'd1;
    p1_read = 1'b1; p1_address = 18'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_grant_seq", grant, t2_exp[i]);
      check("t2_m_read", m_read, t2_exp[i] != 2'b00);
    end
    @(posedge clk); #1;
    p0_read = 1'b0; p1_read = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a stalled write.
    stall_cfg[1] = 100;
    p1_write = 1'b1; p1_address = 18'd7; p1_writedata = 36'hFFFFFFFFF;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy && m_write) begin found = 1'b1; break; end
    end
    check("t5_reached_write", found, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset", {busy, grant, m_read, m_write, p0_wait, p1_wait}, 7'b0000011);
    p1_write = 1'b0; p1_address = '0; p1_writedata = '0;
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    stall_cfg[1] = 0;
    @(posedge clk); #1;
    p0_read = 1'b1; p1_read = 1'b1;
    wait_busy(found);
    check("t5_first_grant", grant, 2'b01);
    @(posedge clk); #1;
    p0_read = 1'b0; p1_read = 1'b0;

    // Abort by port 1 leaves the pointer alone; port 1 then wins the tie.
    stall_cfg[1] = 100;
    p1_read = 1'b1; p1_address = 18'd3;
    wait_busy(found);
    check("t6_grant", grant, 2'b10);
    @(posedge clk); #1;
    p1_read = 1'b0;
    @(negedge clk);
    check("t6_abort_cycle_read", m_read, 1'b0);
    @(negedge clk);
    check("t6_back_to_idle", busy, 1'b0);
    stall_cfg[1] = 0;
    @(posedge clk); #1;
    p0_read = 1'b1; p1_read = 1'b1;
    wait_busy(found);
    check("t6_same_port_wins", grant, 2'b10);
    @(posedge clk); #1;
    p0_read = 1'b0; p1_read = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic from both ports with random slave stalls.
    sb_en      = 1'b1;
    rand_stall = 1'b1;
    fork
      requester(0, 60);
      requester(1, 60);
    join
    rand_stall = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("sb_drained", q0.size() + q1.size(), 0);

    // Fixed priority: port 0 takes every grant while it keeps requesting.
    fp_p0_read = 1'b1; fp_p1_read = 1'b1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (fp_busy) begin
        cnt++;
        check("t3_fp_grant", fp_grant, 2'b01);
        check("t3_fp_bus", {fp_m_read, fp_m_write, fp_p0_wait, fp_p1_wait, fp_m_address},
              {1'b1, 1'b0, 1'b0, 1'b1, 18'd1});
        check("t3_fp_data", {fp_p0_rdata, fp_p1_rdata, fp_m_writedata}, 108'd0);
      end
    end
    check("t3_grant_count", cnt, 8);
    @(posedge clk); #1;
    fp_p0_read = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fp_busy) break;
    end
    check("t3_port1_after_drop", fp_grant, 2'b10);
    @(posedge clk); #1;
    fp_p1_read = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
